// File: rtl/astar_path_raster.sv
// ---------------------------------------------------------------------------
// astar_path_raster
//
// This block captures the node list from the A* reconstruct stage into a
// GRID_H x GRID_W bitmap, with one bit per cell. The display side can then
// query any cell to ask whether it lies on the captured path.
//
// Every capture starts with a row-by-row clear of the bitmap. For that reason
// reset never has to touch the bitmap storage. Stale contents stay invisible
// because draw_path is masked whenever the block is not in SHOW.
//
// Optional feature (macro ASTAR_PATH_BOUNDS_CHECK_EN):
//   defined   : an accepted out-of-range node sets the sticky err flag.
//   undefined : err is tied low, and out-of-range nodes are dropped silently.
//
// Ports:
//   sync       clock, all logic on its rising edge
//   reset      synchronous active-high reset
//   start      one-cycle pulse that begins a new capture (IDLE/SHOW only)
//   in_valid   path node present
//   in_x/in_y  node column/row
//   in_last    final node of the path
//   in_ready   high exactly while collecting nodes
//   gridx/y    display query column/row
//   draw_path  registered: the queried cell is on the path (SHOW only)
//   path_len   number of distinct path cells captured
//   busy       clearing or collecting
//   done       capture complete, bitmap valid for display
//   err        sticky out-of-range node flag
// ---------------------------------------------------------------------------
module astar_path_raster #(
    parameter int GRID_W  = 40,
    parameter int GRID_H  = 40,
    parameter int COORD_W = 6
) (
    input  logic               sync,
    input  logic               reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic [COORD_W-1:0] in_x,
    input  logic [COORD_W-1:0] in_y,
    input  logic               in_last,
    output logic               in_ready,
    input  logic [COORD_W-1:0] gridx,
    input  logic [COORD_W-1:0] gridy,
    output logic               draw_path,
    output logic [10:0]        path_len,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, CLEAR, COLLECT, SHOW} state_t;

    localparam logic [10:0] PATH_MAX = 11'(GRID_W * GRID_H);

    state_t             state;
    state_t             state_next;
    logic [GRID_W-1:0]  bitmap [GRID_H];
    logic [COORD_W-1:0] clr_row;
    logic               start_clear;
    logic               node_accept;
    logic               node_in_range;
    logic               node_is_new;
    logic               query_in_range;
    logic               last_row;

    assign node_in_range  = (int'(in_x) < GRID_W) && (int'(in_y) < GRID_H);
    assign query_in_range = (int'(gridx) < GRID_W) && (int'(gridy) < GRID_H);
    assign node_is_new    = node_in_range && !bitmap[in_y][in_x];
    assign last_row       = (clr_row == COORD_W'(GRID_H - 1));
    assign start_clear    = start && ((state == IDLE) || (state == SHOW));
    assign node_accept    = in_valid && (state == COLLECT);

    // State register
    always_ff @(posedge sync) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and state-decoded outputs.
    // in_ready depends on state only, so there is no path back from in_valid.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = CLEAR;
            end
            CLEAR: begin
                busy = 1'b1;
                if (last_row) state_next = COLLECT;
            end
            COLLECT: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (in_valid && in_last) state_next = SHOW;
            end
            SHOW: begin
                done = 1'b1;
                if (start) state_next = CLEAR;
            end
            default: state_next = IDLE;
        endcase
    end

    // Clear-row counter, distinct-cell count and the registered query result.
    // The count saturates at the grid size; this is only a safety guard,
    // because duplicates are never counted.
    always_ff @(posedge sync) begin
        if (reset) begin
            clr_row   <= '0;
            path_len  <= '0;
            draw_path <= 1'b0;
        end else begin
            if (start_clear) begin
                clr_row  <= '0;
                path_len <= '0;
            end else if (state == CLEAR) begin
                clr_row <= clr_row + 1'b1;
            end
            if (node_accept && node_is_new && (path_len != PATH_MAX)) begin
                path_len <= path_len + 1'b1;
            end
            draw_path <= (state == SHOW) && query_in_range && bitmap[gridy][gridx];
        end
    end

    // Bitmap storage. It has no reset on purpose: CLEAR always precedes COLLECT.
    always_ff @(posedge sync) begin
        if (!reset) begin
            if (state == CLEAR) begin
                bitmap[clr_row] <= '0;
            end else if (node_accept && node_in_range) begin
                bitmap[in_y][in_x] <= 1'b1;
            end
        end
    end

`ifdef ASTAR_PATH_BOUNDS_CHECK_EN
    // Sticky flag for a dropped out-of-range node; cleared by a new capture
    always_ff @(posedge sync) begin
        if (reset) begin
            err <= 1'b0;
        end else if (start_clear) begin
            err <= 1'b0;
        end else if (node_accept && !node_in_range) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_astar_path_raster.sv
// ---------------------------------------------------------------------------
// tb_astar_path_raster
//
// Directed testbench for astar_path_raster.
//
// A behavioural model tracks the captured path as a set of cells, and tracks
// the capture phase from the clear-cycle count. A compare process checks every
// DUT output against this model on each falling edge.
//
// Hand-computed literal expectations at the key points pin the model itself.
// ---------------------------------------------------------------------------
module tb_astar_path_raster;

    localparam int GW = 40;
    localparam int GH = 40;
    localparam int CW = 6;

`ifdef ASTAR_PATH_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic          sync     = 1'b0;
    logic          reset    = 1'b0;
    logic          start    = 1'b0;
    logic          in_valid = 1'b0;
    logic [CW-1:0] in_x     = '0;
    logic [CW-1:0] in_y     = '0;
    logic          in_last  = 1'b0;
    logic [CW-1:0] gridx    = '0;
    logic [CW-1:0] gridy    = '0;
    logic          in_ready;
    logic          draw_path;
    logic [10:0]   path_len;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;

    astar_path_raster #(.GRID_W(GW), .GRID_H(GH), .COORD_W(CW)) dut (
        .sync      (sync),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_x      (in_x),
        .in_y      (in_y),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .gridx     (gridx),
        .gridy     (gridy),
        .draw_path (draw_path),
        .path_len  (path_len),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 sync = ~sync;

    // Shared comparison routine used by the model checker and the literal checks
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: the path is a set of cells keyed by y*64+x, and the
    // capture phase is tracked from how many clear cycles have elapsed.
    typedef enum {M_IDLE, M_CLEAR, M_COLLECT, M_SHOW} mphase_t;
    mphase_t m_phase = M_IDLE;
    int      m_clear_cycles = 0;
    bit      m_cells [int];
    bit      m_err   = 1'b0;
    bit      m_draw  = 1'b0;
    bit      m_valid = 1'b0;

    function automatic bit inGrid(input int x, input int y);
        return (x < GW) && (y < GH);
    endfunction

    always @(posedge sync) begin
        if (reset) begin
            m_phase = M_IDLE;
            m_err   = 1'b0;
            m_draw  = 1'b0;
            m_cells.delete();
            m_valid = 1'b1;
        end else begin
            m_draw = (m_phase == M_SHOW) && inGrid(int'(gridx), int'(gridy))
                     && m_cells.exists(int'(gridy) * 64 + int'(gridx));
            case (m_phase)
                M_IDLE, M_SHOW: begin
                    if (start) begin
                        m_phase        = M_CLEAR;
                        m_clear_cycles = 0;
                        m_cells.delete();
                        m_err          = 1'b0;
                    end
                end
                M_CLEAR: begin
                    m_clear_cycles++;
                    if (m_clear_cycles == GH) m_phase = M_COLLECT;
                end
                M_COLLECT: begin
                    if (in_valid) begin
                        if (inGrid(int'(in_x), int'(in_y))) m_cells[int'(in_y) * 64 + int'(in_x)] = 1'b1;
                        else if (BOUNDS_EN) m_err = 1'b1;
                        if (in_last) m_phase = M_SHOW;
                    end
                end
                default: m_phase = M_IDLE;
            endcase
        end
    end

    // Compare every output against the model once the model has seen a reset
    always @(negedge sync) begin
        if (m_valid) begin
            checkOutput("in_ready", in_ready, m_phase == M_COLLECT);
            checkOutput("busy", busy, (m_phase == M_CLEAR) || (m_phase == M_COLLECT));
            checkOutput("done", done, m_phase == M_SHOW);
            checkOutput("draw_path", draw_path, m_draw);
            checkOutput("path_len", path_len, m_cells.size());
            checkOutput("err", err, m_err);
        end
    end

    task automatic applyStimulus(input bit rst, input bit st, input bit v, input int x, input int y,
                                 input bit lst, input int gx, input int gy);
        @(negedge sync);
        reset    = rst;
        start    = st;
        in_valid = v;
        in_x     = CW'(x);
        in_y     = CW'(y);
        in_last  = lst;
        gridx    = CW'(gx);
        gridy    = CW'(gy);
    endtask

    task automatic idleCycle(input int gx, input int gy);
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 1'b0, gx, gy);
    endtask

    task automatic sendNode(input int x, input int y, input bit lst);
        applyStimulus(1'b0, 1'b0, 1'b1, x, y, lst, 0, 0);
    endtask

    task automatic pulseStart();
        applyStimulus(1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic waitCollect();
        for (int i = 0; i < 100 && in_ready !== 1'b1; i++) idleCycle(0, 0);
        checkOutput("collect_timeout", in_ready, 1);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 0);
        applyStimulus(1'b1, 1'b1, 1'b1, 3, 3, 1'b1, 0, 0);
        idleCycle(0, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_in_ready", in_ready, 0);
        checkOutput("reset_path_len", path_len, 0);

        // Clear takes 40 cycles, and in_ready rises at cycle 41
        pulseStart();
        idleCycle(0, 0);
        checkOutput("c1_busy", busy, 1);
        checkOutput("c1_in_ready", in_ready, 0);
        repeat (39) idleCycle(0, 0);
        checkOutput("c40_in_ready", in_ready, 0);
        sendNode(0, 0, 1'b0);
        checkOutput("c41_in_ready", in_ready, 1);
        sendNode(1, 1, 1'b0);
        sendNode(39, 39, 1'b1);
        idleCycle(39, 39);
        checkOutput("p1_done", done, 1);
        checkOutput("p1_path_len", path_len, 3);
        idleCycle(2, 2);
        checkOutput("p1_draw_39_39", draw_path, 1);
        idleCycle(0, 0);
        checkOutput("p1_draw_2_2", draw_path, 0);
        idleCycle(40, 0);
        checkOutput("p1_draw_0_0", draw_path, 1);
        idleCycle(0, 40);
        idleCycle(63, 63);
        idleCycle(1, 1);
        idleCycle(39, 0);
        idleCycle(0, 0);

        // Duplicate nodes are counted once; a start pulse during CLEAR is ignored
        pulseStart();
        repeat (3) idleCycle(0, 0);
        pulseStart();
        waitCollect();
        sendNode(5, 5, 1'b0);
        sendNode(5, 5, 1'b0);
        sendNode(6, 5, 1'b1);
        idleCycle(6, 5);
        checkOutput("p2_path_len", path_len, 2);
        idleCycle(5, 6);
        checkOutput("p2_draw_6_5", draw_path, 1);
        idleCycle(0, 0);

        // An out-of-range node completes the handshake but is not stored
        pulseStart();
        waitCollect();
        sendNode(40, 3, 1'b0);
        sendNode(3, 3, 1'b1);
        idleCycle(40, 3);
        checkOutput("p3_path_len", path_len, 1);
        checkOutput("p3_err", err, BOUNDS_EN);
        idleCycle(3, 3);
        checkOutput("p3_draw_40_3", draw_path, 0);
        idleCycle(0, 0);
        checkOutput("p3_draw_3_3", draw_path, 1);

        // Reset mid-collect abandons the capture; the old path must not show
        pulseStart();
        checkOutput("p4_err_before_clear", err, BOUNDS_EN);
        waitCollect();
        sendNode(0, 0, 1'b0);
        sendNode(1, 1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2, 2, 1'b0, 0, 0);
        idleCycle(0, 0);
        checkOutput("p4_rst_in_ready", in_ready, 0);
        checkOutput("p4_rst_busy", busy, 0);
        checkOutput("p4_rst_done", done, 0);
        checkOutput("p4_rst_draw", draw_path, 0);
        checkOutput("p4_rst_path_len", path_len, 0);
        checkOutput("p4_rst_err", err, 0);
        pulseStart();
        waitCollect();
        sendNode(7, 7, 1'b1);
        idleCycle(0, 0);
        idleCycle(7, 7);
        checkOutput("p4_draw_0_0", draw_path, 0);
        checkOutput("p4_path_len", path_len, 1);
        idleCycle(0, 0);
        checkOutput("p4_draw_7_7", draw_path, 1);

        // A start pulse that coincides with an accepted node is ignored
        pulseStart();
        waitCollect();
        sendNode(2, 2, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1, 9, 9, 1'b0, 0, 0);
        idleCycle(0, 0);
        checkOutput("p5_in_ready", in_ready, 1);
        checkOutput("p5_busy", busy, 1);
        checkOutput("p5_path_len", path_len, 2);
        repeat (3) idleCycle(0, 0);
        checkOutput("p5_still_collect", in_ready, 1);
        sendNode(9, 9, 1'b1);
        idleCycle(9, 9);
        checkOutput("p5_done", done, 1);
        checkOutput("p5_final_len", path_len, 2);
        idleCycle(0, 0);

        // Fill every cell: the count reaches the full grid size
        pulseStart();
        waitCollect();
        for (int y = 0; y < GH; y++) begin
            for (int x = 0; x < GW; x++) begin
                sendNode(x, y, (x == GW - 1) && (y == GH - 1));
            end
        end
        idleCycle(20, 20);
        checkOutput("p6_path_len", path_len, 1600);
        idleCycle(39, 0);
        checkOutput("p6_draw_20_20", draw_path, 1);
        idleCycle(0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
